// File: rtl/reg_file_wb_arb_if.sv
// Writeback arbiter bus bundle: ALU and LSU result channels, register-file
// write port, and the hazard/occupancy status exported to issue.
interface reg_file_wb_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
);
  logic                          alu_valid;
  logic                          alu_ready;
  logic [ADDR_WIDTH-1:0]         alu_rd;
  logic [DATA_WIDTH-1:0]         alu_data;
  logic                          lsu_valid;
  logic                          lsu_ready;
  logic [ADDR_WIDTH-1:0]         lsu_rd;
  logic [DATA_WIDTH-1:0]         lsu_data;
  logic                          wr_en;
  logic [ADDR_WIDTH-1:0]         wr_reg;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [(2**ADDR_WIDTH)-1:0]    pending_mask;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready, wr_en, wr_reg, wr_data, pending_mask, fifo_count
  );

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready, wr_en, wr_reg, wr_data, pending_mask, fifo_count
  );
endinterface

// File: rtl/reg_file_wb_arb.sv
// Writeback arbiter: ALU results go straight to the register-file write port,
// LSU loads queue in an in-order FIFO; ALU has priority with a starvation guard.
module reg_file_wb_arb #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_file_wb_arb_if.slave bus
);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] rd_mem   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [SW-1:0]         starve_cnt;

  logic                  fifo_empty, force_lsu, push, pop, alu_grant;
  logic                  grant_vld_p0;
  logic [ADDR_WIDTH-1:0] grant_rd_p0;
  logic [DATA_WIDTH-1:0] grant_data_p0;
  logic                  wr_en_p1;
  logic [ADDR_WIDTH-1:0] wr_reg_p1;
  logic [DATA_WIDTH-1:0] wr_data_p1;
  logic [NREG-1:0]       mask;

  // Counter only runs while the FIFO holds something and the ALU keeps winning.
  function automatic logic [SW-1:0] starve_next(input logic [SW-1:0] cnt,
                                                input logic alu_g,
                                                input logic empty,
                                                input logic popped);
    if (popped || empty)              return '0;
    else if (!alu_g)                  return cnt;
    else if (cnt == SW'(STARVE_LIMIT)) return cnt;
    else                              return cnt + SW'(1);
  endfunction

  // p0: grant selection
  always_comb begin
    fifo_empty    = (count == '0);
    force_lsu     = (starve_cnt == SW'(STARVE_LIMIT)) && !fifo_empty;
    push          = bus.lsu_valid && (count < CW'(FIFO_DEPTH));
    alu_grant     = bus.alu_valid && !force_lsu;
    pop           = !fifo_empty && (force_lsu || !bus.alu_valid);
    grant_vld_p0  = alu_grant || pop;
    grant_rd_p0   = alu_grant ? bus.alu_rd   : rd_mem[rd_ptr];
    grant_data_p0 = alu_grant ? bus.alu_data : data_mem[rd_ptr];
  end

  // Mask reflects stored entries; the head stays visible until its pop edge.
  always_comb begin
    mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ((CW'(i) < count) && (rd_mem[rd_ptr + PW'(i)] != '0))
        mask[rd_mem[rd_ptr + PW'(i)]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= bus.lsu_rd;
      data_mem[wr_ptr] <= bus.lsu_data;
    end
  end

  // p1: registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      wr_en_p1   <= 1'b0;
      wr_reg_p1  <= '0;
      wr_data_p1 <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      starve_cnt <= starve_next(starve_cnt, alu_grant, fifo_empty, pop);
      wr_en_p1   <= grant_vld_p0 && (grant_rd_p0 != '0);
      if (grant_vld_p0 && (grant_rd_p0 != '0)) begin
        wr_reg_p1  <= grant_rd_p0;
        wr_data_p1 <= grant_data_p0;
      end
    end
  end

  assign bus.alu_ready    = !force_lsu;
  assign bus.lsu_ready    = (count < CW'(FIFO_DEPTH));
  assign bus.wr_en        = wr_en_p1;
  assign bus.wr_reg       = wr_reg_p1;
  assign bus.wr_data      = wr_data_p1;
  assign bus.pending_mask = mask;
  assign bus.fifo_count   = count;
endmodule
